// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path: default word/clip sizes and
// the capture controller state encoding.
package audio_pkg;

    localparam int DEF_SAMPLE_BITS = 16;
    localparam int DEF_CLIP_LEN    = 256;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DONE
    } capture_state_t;

endpackage

// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: synchronizes the codec lines into clk, detects bit
// clock rising edges and assembles left/right words MSB first.
module i2s_rx_deser
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   bclk,
    input  logic                   lrclk,
    input  logic                   sdata,
    output logic [SAMPLE_BITS-1:0] left_word,
    output logic [SAMPLE_BITS-1:0] right_word,
    output logic                   frame_strobe
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(SAMPLE_BITS);
    localparam logic [SAMPLE_BITS-1:0] MSB_MASK = SAMPLE_BITS'(1) << (SAMPLE_BITS - 1);

    logic [2:0]             bclk_sync;
    logic [1:0]             lr_sync;
    logic [1:0]             dat_sync;
    logic                   lr_prev;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] word_final;
    logic [SAMPLE_BITS-1:0] right_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   bclk_rise;
    logic                   boundary;
    logic                   take_bit;

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign boundary  = bclk_rise && (lr_sync[1] != lr_prev);
    assign take_bit  = bit_cnt < CNT_FULL;

    // The bit arriving on a boundary edge is the LSB of the word that is ending
    // (one-bit I2S delay), so it is merged before the word is latched.
    always_comb begin
        word_final = shreg;
        if (take_bit && dat_sync[1]) begin
            word_final = shreg | (MSB_MASK >> bit_cnt);
        end
    end

    assign frame_strobe = boundary && !lr_sync[1];
    assign right_word   = frame_strobe ? word_final : right_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            lr_prev   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            left_word <= '0;
            right_q   <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk};
            lr_sync   <= {lr_sync[0], lrclk};
            dat_sync  <= {dat_sync[0], sdata};
            if (boundary) begin
                lr_prev <= lr_sync[1];
                shreg   <= '0;
                bit_cnt <= '0;
                if (lr_sync[1]) begin
                    left_word <= word_final;
                end else begin
                    right_q <= word_final;
                end
            end else if (bclk_rise && take_bit) begin
                shreg   <= word_final;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_capture_writer.sv
// Captures CLIP_LEN stereo I2S frames into a BRAM port, one 32-bit word per
// frame, starting at a left-word boundary after arm.
module i2s_capture_writer
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int CLIP_LEN    = DEF_CLIP_LEN
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      audio_I2S_bclk,
    input  logic                      audio_I2S_reclrc,
    input  logic                      audio_I2S_recdat,
    input  logic                      arm,
    output logic                      BRAM_clk,
    output logic [31:0]               BRAM_addr,
    output logic [31:0]               BRAM_din,
    output logic                      BRAM_en,
    output logic [3:0]                BRAM_we,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(CLIP_LEN):0] frame_count
);

    localparam int FC_W = $clog2(CLIP_LEN) + 1;
    localparam logic [FC_W-1:0] FC_FULL = FC_W'(CLIP_LEN);

    capture_state_t         state;
    logic [SAMPLE_BITS-1:0] left_word;
    logic [SAMPLE_BITS-1:0] right_word;
    logic                   frame_strobe;

    assign BRAM_clk = clk;

    i2s_rx_deser #(
        .SAMPLE_BITS(SAMPLE_BITS)
    ) u_deser (
        .clk         (clk),
        .rstn        (rstn),
        .bclk        (audio_I2S_bclk),
        .lrclk       (audio_I2S_reclrc),
        .sdata       (audio_I2S_recdat),
        .left_word   (left_word),
        .right_word  (right_word),
        .frame_strobe(frame_strobe)
    );

    // The first left-word boundary only aligns the capture; every later one
    // closes a complete {right, left} pair that is written out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
            BRAM_en     <= 1'b0;
            BRAM_we     <= 4'h0;
            BRAM_addr   <= '0;
            BRAM_din    <= '0;
        end else begin
            BRAM_en <= 1'b0;
            BRAM_we <= 4'h0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state       <= WAIT_FRAME;
                        busy        <= 1'b1;
                        frame_count <= '0;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_strobe) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (frame_count == FC_FULL) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (frame_strobe) begin
                        BRAM_en     <= 1'b1;
                        BRAM_we     <= 4'hF;
                        BRAM_addr   <= 32'(frame_count) << 2;
                        BRAM_din    <= {16'(right_word), 16'(left_word)};
                        frame_count <= frame_count + 1'b1;
                    end
                end
                DONE: begin
                    if (arm) begin
                        state       <= WAIT_FRAME;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        frame_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_capture_writer.sv
// Self-checking bench for i2s_capture_writer: drives I2S slot streams and
// compares BRAM writes with frames predicted from the transmitted words.
module tb_i2s_capture_writer;

    localparam int SAMPLE_BITS = 16;
    localparam int CLIP_LEN    = 256;
    localparam int FC_W        = $clog2(CLIP_LEN) + 1;

    logic            clk   = 1'b0;
    logic            rstn  = 1'b0;
    logic            bclk  = 1'b0;
    logic            lrclk = 1'b0;
    logic            sdata = 1'b0;
    logic            arm   = 1'b0;
    logic            BRAM_clk;
    logic [31:0]     BRAM_addr;
    logic [31:0]     BRAM_din;
    logic            BRAM_en;
    logic [3:0]      BRAM_we;
    logic            busy;
    logic            done;
    logic [FC_W-1:0] frame_count;

    int          checks     = 0;
    int          errors     = 0;
    int          write_idx  = 0;
    int          cap_writes = 0;
    logic [31:0] exp_q[$];
    logic        tail_bit   = 1'b0;
    logic [31:0] fl[16];
    logic [31:0] fr[16];

    i2s_capture_writer #(
        .SAMPLE_BITS(SAMPLE_BITS),
        .CLIP_LEN   (CLIP_LEN)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .audio_I2S_bclk  (bclk),
        .audio_I2S_reclrc(lrclk),
        .audio_I2S_recdat(sdata),
        .arm             (arm),
        .BRAM_clk        (BRAM_clk),
        .BRAM_addr       (BRAM_addr),
        .BRAM_din        (BRAM_din),
        .BRAM_en         (BRAM_en),
        .BRAM_we         (BRAM_we),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One bit-clock period: word select and data change while bclk is low.
    task automatic applyStimulus(input logic lr, input logic d);
        lrclk = lr;
        sdata = d;
        #20 bclk = 1'b1;
        #20 bclk = 1'b0;
    endtask

    // Stored value: the first 16 transmitted bits, left-aligned if the word is shorter.
    function automatic logic [15:0] align16(input logic [31:0] w, input int wbits);
        if (wbits >= 16) return 16'(w >> (wbits - 16));
        return 16'(w << (16 - wbits));
    endfunction

    task automatic send_slot(input logic lr, input logic [31:0] word, input int wbits,
                             input int slot_len, input int arm_bit);
        logic [63:0] bits;
        logic [31:0] tmp;
        logic        b;
        bits = '0;
        for (int k = 0; k < slot_len; k++) begin
            if (k < wbits) begin
                tmp     = word >> (wbits - 1 - k);
                bits[k] = tmp[0];
            end else begin
                bits[k] = 1'($urandom_range(0, 1));
            end
        end
        for (int j = 0; j < slot_len; j++) begin
            if (j == arm_bit) arm = 1'b1;
            if (j == 0) b = tail_bit;
            else        b = bits[j-1];
            applyStimulus(lr, b);
        end
        tail_bit = bits[slot_len-1];
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int wbits, input int slot_len);
        send_slot(1'b0, l, wbits, slot_len, -1);
        send_slot(1'b1, r, wbits, slot_len, -1);
    endtask

    task automatic send_tail();
        applyStimulus(1'b0, tail_bit);
        repeat (2) applyStimulus(1'b0, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [31:0] l, input logic [31:0] r, input int wbits);
        exp_q.push_back({align16(r, wbits), align16(l, wbits)});
    endtask

    task automatic start_capture();
        write_idx  = 0;
        cap_writes = 0;
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (BRAM_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("queued_frames_at_write", 32'(exp_q.size()), 32'd1);
            end else begin
                checkOutput("wr_din", BRAM_din, exp_q.pop_front());
                checkOutput("wr_addr", BRAM_addr, 32'(write_idx * 4));
                checkOutput("wr_we", 32'(BRAM_we), 32'hF);
            end
            write_idx++;
            cap_writes++;
        end else if (BRAM_we != 4'h0) begin
            checkOutput("we_without_en", 32'(BRAM_we), 32'h0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_en", 32'(BRAM_en), 32'h0);
        checkOutput("rst_we", 32'(BRAM_we), 32'h0);
        checkOutput("rst_addr", BRAM_addr, 32'h0);
        checkOutput("rst_din", BRAM_din, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'h0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("bram_clk_low", 32'(BRAM_clk), 32'(clk));

        $display("[TB] full clip of 16'h1234/16'hABCD with arm pulsed mid-capture");
        for (int i = 0; i < CLIP_LEN; i++) expect_frame(32'h1234, 32'hABCD, 16);
        start_capture();
        checkOutput("busy_after_arm", 32'(busy), 32'h1);
        send_frame(32'($urandom), 32'($urandom), 16, 16);
        for (int i = 0; i < CLIP_LEN; i++) begin
            if (i == 100) arm = 1'b1;
            send_frame(32'h1234, 32'hABCD, 16, 16);
            arm = 1'b0;
        end
        send_tail();
        checkOutput("clip_writes", 32'(cap_writes), 32'(CLIP_LEN));
        checkOutput("clip_pending", 32'(exp_q.size()), 32'h0);
        checkOutput("clip_done", 32'(done), 32'h1);
        checkOutput("clip_busy", 32'(busy), 32'h0);
        checkOutput("clip_frame_count", 32'(frame_count), 32'(CLIP_LEN));
        checkOutput("clip_last_addr", BRAM_addr, 32'((CLIP_LEN - 1) * 4));
        send_frame(32'($urandom), 32'($urandom), 16, 16);
        send_tail();
        checkOutput("no_write_in_done", 32'(cap_writes), 32'(CLIP_LEN));

        $display("[TB] re-arm from DONE, reset after 10 writes");
        for (int i = 0; i < 12; i++) begin
            fl[i] = 32'($urandom_range(0, 16'hFFFF));
            fr[i] = 32'($urandom_range(0, 16'hFFFF));
        end
        for (int i = 1; i <= 10; i++) expect_frame(fl[i], fr[i], 16);
        start_capture();
        checkOutput("rearm_done", 32'(done), 32'h0);
        checkOutput("rearm_frame_count", 32'(frame_count), 32'h0);
        for (int i = 0; i <= 10; i++) send_frame(fl[i], fr[i], 16, 16);
        send_tail();
        checkOutput("rearm_writes", 32'(cap_writes), 32'd10);
        checkOutput("rearm_frame_count10", 32'(frame_count), 32'd10);
        repeat (3) applyStimulus(1'b0, 1'b1);
        #3 rstn = 1'b0;
        #1;
        checkOutput("arst_en", 32'(BRAM_en), 32'h0);
        checkOutput("arst_we", 32'(BRAM_we), 32'h0);
        checkOutput("arst_addr", BRAM_addr, 32'h0);
        checkOutput("arst_din", BRAM_din, 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_frame_count", 32'(frame_count), 32'h0);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(32'($urandom), 32'($urandom), 16, 16);
        send_tail();
        checkOutput("no_write_after_reset", 32'(cap_writes), 32'd10);
        checkOutput("idle_after_reset", 32'(busy), 32'h0);

        $display("[TB] arm asserted in the middle of a right word");
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            fl[i] = 32'($urandom_range(0, 16'hFFFF));
            fr[i] = 32'($urandom_range(0, 16'hFFFF));
        end
        for (int i = 1; i < 4; i++) expect_frame(fl[i], fr[i], 16);
        write_idx  = 0;
        cap_writes = 0;
        send_slot(1'b0, fl[0], 16, 16, -1);
        send_slot(1'b1, fr[0], 16, 16, 7);
        arm = 1'b0;
        for (int i = 1; i < 4; i++) send_frame(fl[i], fr[i], 16, 16);
        send_tail();
        checkOutput("midarm_writes", 32'(cap_writes), 32'd3);
        checkOutput("midarm_pending", 32'(exp_q.size()), 32'h0);

        $display("[TB] 32-bit slots, trailing bits ignored");
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            fl[i] = {16'h8001, 16'($urandom)};
            fr[i] = 32'($urandom);
        end
        for (int i = 1; i < 4; i++) expect_frame(fl[i], fr[i], 32);
        start_capture();
        for (int i = 0; i < 4; i++) send_frame(fl[i], fr[i], 32, 32);
        send_tail();
        checkOutput("slot32_writes", 32'(cap_writes), 32'd3);
        checkOutput("slot32_left", 32'(BRAM_din[15:0]), 32'h8001);

        $display("[TB] 12-bit words cut short by the boundary");
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            fl[i] = 32'h0FFF;
            fr[i] = 32'($urandom_range(0, 12'hFFF));
        end
        for (int i = 1; i < 4; i++) expect_frame(fl[i], fr[i], 12);
        start_capture();
        for (int i = 0; i < 4; i++) send_frame(fl[i], fr[i], 12, 12);
        send_tail();
        checkOutput("w12_writes", 32'(cap_writes), 32'd3);
        checkOutput("w12_left", 32'(BRAM_din[15:0]), 32'hFFF0);
        checkOutput("w12_pending", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
